// File: rtl/rv32_mod_instruction_prefetch.sv
// Instruction prefetcher: single-outstanding bus fetcher feeding a DEPTH-entry FIFO, with redirect flush.
// Latency: ack -> if_valid next cycle; redirect -> new request next cycle unless a response must be drained.
// Backpressure: no new request while the FIFO is full; requests resume the cycle after a pop.
module rv32_mod_instruction_prefetch #(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        instr_req,
    input  logic        instr_ack,
    input  logic        instr_err,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data_i,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instruction,
    output logic [31:0] if_address,
    output logic        if_err,
    input  logic        redirect_enable,
    input  logic [31:0] redirect_address
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [31:0]     RESET_PC = {RESET_ADDR[31:2], 2'b00};

    typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   drain_addr_q, drain_addr_d;
    logic [CW-1:0] count_q;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]   mem_data [DEPTH];
    logic [31:0]   mem_addr [DEPTH];
    logic          mem_err  [DEPTH];
    logic          req_c, resp, push, push_err, pop;
    logic          unused_addr_bits;

    assign unused_addr_bits = &{1'b0, redirect_address[1:0]};
    // err wins over ack when both are asserted
    assign resp = instr_ack | instr_err;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        req_c        = 1'b0;
        push         = 1'b0;
        push_err     = 1'b0;
        case (state_q)
            FETCH: begin
                req_c = (count_q < DEPTH_C);
                if (redirect_enable) begin
                    // an unanswered request must still be completed on the bus
                    if (req_c && !resp) begin
                        state_d      = DRAIN;
                        drain_addr_d = fetch_pc_q;
                    end
                end else if (req_c && instr_err) begin
                    push     = 1'b1;
                    push_err = 1'b1;
                    state_d  = HALT;
                end else if (req_c && instr_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
            end
            DRAIN: begin
                req_c = 1'b1;
                if (resp) state_d = FETCH;
            end
            HALT: begin
                if (redirect_enable) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (redirect_enable) fetch_pc_d = {redirect_address[31:2], 2'b00};
    end

    assign pop        = if_valid && if_ready && !redirect_enable;
    assign instr_req  = req_c && !reset;
    assign instr_addr = reset ? 32'h0 : ((state_q == DRAIN) ? drain_addr_q : fetch_pc_q);

    assign if_valid       = (count_q != '0);
    assign if_instruction = if_valid ? mem_data[rd_ptr_q] : 32'h0;
    assign if_address     = if_valid ? mem_addr[rd_ptr_q] : 32'h0;
    assign if_err         = if_valid ? mem_err[rd_ptr_q]  : 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH;
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= 32'h0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
            if (redirect_enable) begin
                count_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
                if (push && !pop)      count_q <= count_q + CW'(1);
                else if (pop && !push) count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage needs no reset: head outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= push_err ? 32'h0 : instr_data_i;
            mem_addr[wr_ptr_q] <= fetch_pc_q;
            mem_err[wr_ptr_q]  <= push_err;
        end
    end

endmodule

// File: tb/tb_rv32_mod_instruction_prefetch.sv
// Directed bench for the instruction prefetcher (DEPTH=2, RESET_ADDR=0).
module tb_rv32_mod_instruction_prefetch;

    logic        clk;
    logic        reset;
    logic        instr_req;
    logic        instr_ack;
    logic        instr_err;
    logic [31:0] instr_addr;
    logic [31:0] instr_data_i;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_address;
    logic        if_err;
    logic        redirect_enable;
    logic [31:0] redirect_address;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] PAT = 32'hA5A5_A5A5;

    rv32_mod_instruction_prefetch #(.DEPTH(2), .RESET_ADDR(32'h0)) dut (
        .clk              (clk),
        .reset            (reset),
        .instr_req        (instr_req),
        .instr_ack        (instr_ack),
        .instr_err        (instr_err),
        .instr_addr       (instr_addr),
        .instr_data_i     (instr_data_i),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_instruction   (if_instruction),
        .if_address       (if_address),
        .if_err           (if_err),
        .redirect_enable  (redirect_enable),
        .redirect_address (redirect_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset            = 1'b1;
        instr_ack        = 1'b0;
        instr_err        = 1'b0;
        instr_data_i     = 32'h0;
        if_ready         = 1'b0;
        redirect_enable  = 1'b0;
        redirect_address = 32'h0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        reset     = 1'b1;
        instr_ack = 1'b1;
        @(negedge clk);
        n_cmp++; if (instr_req !== 1'b0)          begin n_bad++; $display("FAIL rst_req: got %b want 0", instr_req); end
        n_cmp++; if (instr_addr !== 32'h0)        begin n_bad++; $display("FAIL rst_addr: got %h want 0", instr_addr); end
        n_cmp++; if (if_valid !== 1'b0)           begin n_bad++; $display("FAIL rst_valid: got %b want 0", if_valid); end
        n_cmp++; if (if_instruction !== 32'h0)    begin n_bad++; $display("FAIL rst_instr: got %h want 0", if_instruction); end
        n_cmp++; if (if_address !== 32'h0)        begin n_bad++; $display("FAIL rst_ifaddr: got %h want 0", if_address); end
        n_cmp++; if (if_err !== 1'b0)             begin n_bad++; $display("FAIL rst_err: got %b want 0", if_err); end
        next_cycle();
        instr_ack = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        n_cmp++; if (instr_req !== 1'b1)          begin n_bad++; $display("FAIL rel_req: got %b want 1", instr_req); end
        n_cmp++; if (instr_addr !== 32'h0)        begin n_bad++; $display("FAIL rel_addr: got %h want 0", instr_addr); end
        next_cycle();
        // request still pending: reset must drop it at once
        reset = 1'b1;
        #1;
        n_cmp++; if (instr_req !== 1'b0)          begin n_bad++; $display("FAIL midreq_rst_req: got %b want 0", instr_req); end
        n_cmp++; if (instr_addr !== 32'h0)        begin n_bad++; $display("FAIL midreq_rst_addr: got %h want 0", instr_addr); end
    endtask

    task automatic test_stream;
        logic [31:0] a;
        logic [31:0] p;
        do_reset();
        if_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a = 32'(k) * 32'd4;
            p = a - 32'd4;
            instr_ack    = 1'b1;
            instr_data_i = a ^ PAT;
            @(negedge clk);
            n_cmp++; if (instr_req !== 1'b1) begin n_bad++; $display("FAIL stream_req k=%0d: got %b want 1", k, instr_req); end
            n_cmp++; if (instr_addr !== a)   begin n_bad++; $display("FAIL stream_addr k=%0d: got %h want %h", k, instr_addr, a); end
            if (k > 0) begin
                n_cmp++; if (if_valid !== 1'b1)           begin n_bad++; $display("FAIL stream_valid k=%0d: got %b want 1", k, if_valid); end
                n_cmp++; if (if_address !== p)            begin n_bad++; $display("FAIL stream_ifaddr k=%0d: got %h want %h", k, if_address, p); end
                n_cmp++; if (if_instruction !== (p ^ PAT)) begin n_bad++; $display("FAIL stream_data k=%0d: got %h want %h", k, if_instruction, p ^ PAT); end
                n_cmp++; if (if_err !== 1'b0)             begin n_bad++; $display("FAIL stream_err k=%0d: got %b want 0", k, if_err); end
            end
            next_cycle();
        end
        instr_ack = 1'b0;
    endtask

    task automatic test_full;
        do_reset();
        if_ready     = 1'b0;
        instr_ack    = 1'b1;
        instr_data_i = 32'h0 ^ PAT;
        next_cycle();
        instr_data_i = 32'h4 ^ PAT;
        next_cycle();
        instr_data_i = 32'h8 ^ PAT;
        for (int c = 2; c < 4; c++) begin
            @(negedge clk);
            n_cmp++; if (instr_req !== 1'b0)     begin n_bad++; $display("FAIL full_req c=%0d: got %b want 0", c, instr_req); end
            n_cmp++; if (instr_addr !== 32'h8)   begin n_bad++; $display("FAIL full_addr c=%0d: got %h want 8", c, instr_addr); end
            n_cmp++; if (if_address !== 32'h0)   begin n_bad++; $display("FAIL full_head c=%0d: got %h want 0", c, if_address); end
            next_cycle();
        end
        if_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (instr_req !== 1'b0)         begin n_bad++; $display("FAIL full_pop_req: got %b want 0", instr_req); end
        next_cycle();
        if_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (instr_req !== 1'b1)         begin n_bad++; $display("FAIL full_resume_req: got %b want 1", instr_req); end
        n_cmp++; if (instr_addr !== 32'h8)       begin n_bad++; $display("FAIL full_resume_addr: got %h want 8", instr_addr); end
        n_cmp++; if (if_address !== 32'h4)       begin n_bad++; $display("FAIL full_head2: got %h want 4", if_address); end
        n_cmp++; if (if_instruction !== (32'h4 ^ PAT)) begin n_bad++; $display("FAIL full_data2: got %h want %h", if_instruction, 32'h4 ^ PAT); end
        next_cycle();
        instr_ack = 1'b0;
    endtask

    task automatic test_redirect_drain;
        do_reset();
        if_ready  = 1'b1;
        instr_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            instr_data_i = (32'(k) * 32'd4) ^ PAT;
            next_cycle();
        end
        instr_ack        = 1'b0;
        redirect_enable  = 1'b1;
        redirect_address = 32'h200;
        @(negedge clk);
        n_cmp++; if (instr_addr !== 32'h10)      begin n_bad++; $display("FAIL rd_pend_addr: got %h want 10", instr_addr); end
        next_cycle();
        redirect_enable = 1'b0;
        for (int c = 5; c < 8; c++) begin
            if (c == 7) begin instr_ack = 1'b1; instr_data_i = 32'hDEAD_BEEF; end
            @(negedge clk);
            n_cmp++; if (instr_req !== 1'b1)     begin n_bad++; $display("FAIL rd_drain_req c=%0d: got %b want 1", c, instr_req); end
            n_cmp++; if (instr_addr !== 32'h10)  begin n_bad++; $display("FAIL rd_drain_addr c=%0d: got %h want 10", c, instr_addr); end
            n_cmp++; if (if_valid !== 1'b0)      begin n_bad++; $display("FAIL rd_drain_valid c=%0d: got %b want 0", c, if_valid); end
            next_cycle();
        end
        instr_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (instr_req !== 1'b1)         begin n_bad++; $display("FAIL rd_new_req: got %b want 1", instr_req); end
        n_cmp++; if (instr_addr !== 32'h200)     begin n_bad++; $display("FAIL rd_new_addr: got %h want 200", instr_addr); end
        n_cmp++; if (if_valid !== 1'b0)          begin n_bad++; $display("FAIL rd_discard_valid: got %b want 0", if_valid); end
        next_cycle();
        instr_ack    = 1'b1;
        instr_data_i = 32'h200 ^ PAT;
        next_cycle();
        instr_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (if_valid !== 1'b1)          begin n_bad++; $display("FAIL rd_after_valid: got %b want 1", if_valid); end
        n_cmp++; if (if_address !== 32'h200)     begin n_bad++; $display("FAIL rd_after_addr: got %h want 200", if_address); end
        n_cmp++; if (if_instruction !== (32'h200 ^ PAT)) begin n_bad++; $display("FAIL rd_after_data: got %h want %h", if_instruction, 32'h200 ^ PAT); end
        next_cycle();
    endtask

    task automatic test_err_halt;
        do_reset();
        if_ready         = 1'b0;
        instr_ack        = 1'b1;
        redirect_enable  = 1'b1;
        redirect_address = 32'h42;
        next_cycle();
        redirect_enable = 1'b0;
        instr_err       = 1'b1;
        instr_data_i    = 32'h1234_5678;
        @(negedge clk);
        n_cmp++; if (instr_addr !== 32'h40)      begin n_bad++; $display("FAIL err_req_addr: got %h want 40", instr_addr); end
        n_cmp++; if (if_valid !== 1'b0)          begin n_bad++; $display("FAIL err_redir_discard: got %b want 0", if_valid); end
        next_cycle();
        instr_ack = 1'b0;
        instr_err = 1'b0;
        @(negedge clk);
        n_cmp++; if (if_valid !== 1'b1)          begin n_bad++; $display("FAIL err_valid: got %b want 1", if_valid); end
        n_cmp++; if (if_err !== 1'b1)            begin n_bad++; $display("FAIL err_flag: got %b want 1", if_err); end
        n_cmp++; if (if_address !== 32'h40)      begin n_bad++; $display("FAIL err_ifaddr: got %h want 40", if_address); end
        n_cmp++; if (if_instruction !== 32'h0)   begin n_bad++; $display("FAIL err_instr: got %h want 0", if_instruction); end
        n_cmp++; if (instr_req !== 1'b0)         begin n_bad++; $display("FAIL err_halt_req: got %b want 0", instr_req); end
        next_cycle();
        instr_ack = 1'b1;
        @(negedge clk);
        n_cmp++; if (instr_req !== 1'b0)         begin n_bad++; $display("FAIL err_halt_req2: got %b want 0", instr_req); end
        next_cycle();
        instr_ack = 1'b0;
        if_ready  = 1'b1;
        @(negedge clk);
        n_cmp++; if (if_address !== 32'h40)      begin n_bad++; $display("FAIL err_no_push: got %h want 40", if_address); end
        next_cycle();
        if_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (if_valid !== 1'b0)          begin n_bad++; $display("FAIL err_popped: got %b want 0", if_valid); end
        n_cmp++; if (instr_req !== 1'b0)         begin n_bad++; $display("FAIL err_halt_req3: got %b want 0", instr_req); end
        redirect_enable  = 1'b1;
        redirect_address = 32'h80;
        next_cycle();
        redirect_enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (instr_req !== 1'b1)         begin n_bad++; $display("FAIL err_resume_req: got %b want 1", instr_req); end
        n_cmp++; if (instr_addr !== 32'h80)      begin n_bad++; $display("FAIL err_resume_addr: got %h want 80", instr_addr); end
        next_cycle();
    endtask

    task automatic test_wrap_and_flush;
        do_reset();
        if_ready         = 1'b0;
        instr_ack        = 1'b1;
        redirect_enable  = 1'b1;
        redirect_address = 32'hFFFF_FFFF;
        next_cycle();
        redirect_enable = 1'b0;
        instr_data_i    = 32'h1111_1111;
        @(negedge clk);
        n_cmp++; if (instr_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_top_addr: got %h want fffffffc", instr_addr); end
        next_cycle();
        instr_data_i = 32'h2222_2222;
        @(negedge clk);
        n_cmp++; if (instr_addr !== 32'h0)         begin n_bad++; $display("FAIL wrap_zero_addr: got %h want 0", instr_addr); end
        n_cmp++; if (if_address !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_head: got %h want fffffffc", if_address); end
        n_cmp++; if (if_instruction !== 32'h1111_1111) begin n_bad++; $display("FAIL wrap_data: got %h want 11111111", if_instruction); end
        next_cycle();
        if_ready         = 1'b1;
        redirect_enable  = 1'b1;
        redirect_address = 32'h300;
        @(negedge clk);
        n_cmp++; if (instr_req !== 1'b0)           begin n_bad++; $display("FAIL wrap_full_req: got %b want 0", instr_req); end
        n_cmp++; if (instr_addr !== 32'h4)         begin n_bad++; $display("FAIL wrap_full_addr: got %h want 4", instr_addr); end
        next_cycle();
        redirect_enable = 1'b0;
        if_ready        = 1'b0;
        instr_data_i    = 32'h3333_3333;
        @(negedge clk);
        n_cmp++; if (if_valid !== 1'b0)            begin n_bad++; $display("FAIL flush_valid: got %b want 0", if_valid); end
        n_cmp++; if (instr_req !== 1'b1)           begin n_bad++; $display("FAIL flush_req: got %b want 1", instr_req); end
        n_cmp++; if (instr_addr !== 32'h300)       begin n_bad++; $display("FAIL flush_addr: got %h want 300", instr_addr); end
        next_cycle();
        instr_ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (if_address !== 32'h300)       begin n_bad++; $display("FAIL flush_head: got %h want 300", if_address); end
        n_cmp++; if (if_instruction !== 32'h3333_3333) begin n_bad++; $display("FAIL flush_data: got %h want 33333333", if_instruction); end
        n_cmp++; if (instr_addr !== 32'h304)       begin n_bad++; $display("FAIL flush_next_addr: got %h want 304", instr_addr); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_drain();
        test_err_halt();
        test_wrap_and_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
